// File: rtl/iq_comp_train_ctrl.sv
// iq_comp_train_ctrl
// Training sequencer for iq_comp. The sequence is BYPASS warm-up, then internal
// W adaptation until Wr/Wj settle, then a one-cycle freeze, then EXT_W replay of
// the latched coefficients. The settled and timeout flags are reported back to the MCU.
// Build option: define IQCTRL_AVG_EN to latch the mean of the last 4 stable
// samples instead of the instantaneous W at the settling sample.
module iq_comp_train_ctrl #(
    parameter int unsigned W_WIDTH     = 13,
    parameter int unsigned WARMUP_N    = 16,
    parameter int unsigned STABLE_N    = 32,
    parameter int unsigned TOL         = 2,
    parameter int unsigned MAX_SAMPLES = 4096
) (
    input  logic                      clk,
    input  logic                      RESETn,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      sample_vld,
    input  logic signed [W_WIDTH-1:0] Wr_mon,
    input  logic signed [W_WIDTH-1:0] Wj_mon,
    output logic [1:0]                op_mode,
    output logic                      freeze_iqcomp,
    output logic signed [W_WIDTH-1:0] Wr_ext,
    output logic signed [W_WIDTH-1:0] Wj_ext,
    output logic                      settled,
    output logic                      timeout,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_ADAPT  = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_INT_W  = 2'b01;
    localparam logic [1:0] MODE_EXT_W  = 2'b10;

    localparam int WW = $clog2(WARMUP_N + 1);
    localparam int SW = $clog2(STABLE_N + 1);
    localparam int CW = $clog2(MAX_SAMPLES + 1);
    localparam int DW = W_WIDTH + 1;

    localparam logic [WW-1:0] WARM_C = WW'(WARMUP_N);
    localparam logic [SW-1:0] STAB_C = SW'(STABLE_N);
    localparam logic [CW-1:0] SAMP_C = CW'(MAX_SAMPLES);
    localparam logic [DW-1:0] TOL_C  = DW'(TOL);

    logic [2:0]                r_state;
    logic [1:0]                r_op_mode;
    logic                      r_freeze;
    logic                      r_settled;
    logic                      r_timeout;
    logic                      r_busy;
    logic signed [W_WIDTH-1:0] r_wr_ext;
    logic signed [W_WIDTH-1:0] r_wj_ext;
    logic [WW-1:0]             r_warm_cnt;
    logic [SW-1:0]             r_stab_cnt;
    logic [CW-1:0]             r_samp_cnt;
    logic signed [W_WIDTH-1:0] r_prev_wr;
    logic signed [W_WIDTH-1:0] r_prev_wj;
    logic                      r_prev_vld;

    logic [2:0]                w_state_nxt;
    logic                      w_capture;
    logic                      w_go;
    logic                      w_adapt_smp;
    logic [WW-1:0]             w_warm_inc;
    logic [SW-1:0]             w_stab_inc;
    logic [SW-1:0]             w_stab_nxt;
    logic [CW-1:0]             w_samp_inc;
    logic signed [DW-1:0]      w_dr;
    logic signed [DW-1:0]      w_dj;
    logic [DW-1:0]             w_adr;
    logic [DW-1:0]             w_adj;
    logic                      w_stable;
    logic signed [W_WIDTH-1:0] w_cap_wr;
    logic signed [W_WIDTH-1:0] w_cap_wj;

    assign w_go        = start && !abort &&
                         ((r_state == ST_IDLE) || (r_state == ST_HOLD) || (r_state == ST_FAIL));
    assign w_adapt_smp = (r_state == ST_ADAPT) && sample_vld && !abort;

    // Saturating increments; counters hold at their terminal value.
    assign w_warm_inc = (r_warm_cnt == WARM_C) ? r_warm_cnt : r_warm_cnt + WW'(1);
    assign w_stab_inc = (r_stab_cnt == STAB_C) ? r_stab_cnt : r_stab_cnt + SW'(1);
    assign w_samp_inc = (r_samp_cnt == SAMP_C) ? r_samp_cnt : r_samp_cnt + CW'(1);

    // One extra bit keeps the sample-to-sample difference from wrapping.
    assign w_dr  = {Wr_mon[W_WIDTH-1], Wr_mon} - {r_prev_wr[W_WIDTH-1], r_prev_wr};
    assign w_dj  = {Wj_mon[W_WIDTH-1], Wj_mon} - {r_prev_wj[W_WIDTH-1], r_prev_wj};
    assign w_adr = w_dr[DW-1] ? (~w_dr) + DW'(1) : w_dr;
    assign w_adj = w_dj[DW-1] ? (~w_dj) + DW'(1) : w_dj;

    // The first ADAPT sample has no valid predecessor and always counts unstable.
    assign w_stable   = r_prev_vld && (w_adr <= TOL_C) && (w_adj <= TOL_C);
    assign w_stab_nxt = w_stable ? w_stab_inc : '0;

`ifdef IQCTRL_AVG_EN
    localparam int AW = W_WIDTH + 2;

    logic signed [W_WIDTH-1:0] r_hist_wr [3];
    logic signed [W_WIDTH-1:0] r_hist_wj [3];
    logic signed [AW-1:0]      w_sum_wr;
    logic signed [AW-1:0]      w_sum_wj;

    // Mean of the current sample and the three before it; all four are stable
    // whenever capture happens because STABLE_N >= 4.
    assign w_sum_wr = AW'(Wr_mon) + AW'(r_hist_wr[0]) + AW'(r_hist_wr[1]) + AW'(r_hist_wr[2]);
    assign w_sum_wj = AW'(Wj_mon) + AW'(r_hist_wj[0]) + AW'(r_hist_wj[1]) + AW'(r_hist_wj[2]);
    assign w_cap_wr = W_WIDTH'(w_sum_wr >>> 2);
    assign w_cap_wj = W_WIDTH'(w_sum_wj >>> 2);

    // History of the last three ADAPT samples, newest in slot 0.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_hist_wr[i] <= '0;
                r_hist_wj[i] <= '0;
            end
        end else if (w_adapt_smp) begin
            r_hist_wr[0] <= Wr_mon;
            r_hist_wj[0] <= Wj_mon;
            r_hist_wr[1] <= r_hist_wr[0];
            r_hist_wj[1] <= r_hist_wj[0];
            r_hist_wr[2] <= r_hist_wr[1];
            r_hist_wj[2] <= r_hist_wj[1];
        end
    end
`else
    assign w_cap_wr = Wr_mon;
    assign w_cap_wj = Wj_mon;
`endif

    // Next-state selection; abort overrides everything, LATCH wins over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD, ST_FAIL: begin
                    if (start) w_state_nxt = ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (sample_vld && (w_warm_inc == WARM_C)) w_state_nxt = ST_ADAPT;
                end
                ST_ADAPT: begin
                    if (sample_vld) begin
                        if (w_stab_nxt == STAB_C) begin
                            w_state_nxt = ST_LATCH;
                            w_capture   = 1'b1;
                        end else if (w_samp_inc == SAMP_C) begin
                            w_state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_LATCH: w_state_nxt = ST_HOLD;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and state-decoded outputs, registered from the state being entered.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_op_mode <= MODE_BYPASS;
            r_freeze  <= 1'b0;
            r_settled <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_freeze  <= (w_state_nxt == ST_LATCH) || (w_state_nxt == ST_HOLD);
            r_settled <= (w_state_nxt == ST_HOLD);
            r_timeout <= (w_state_nxt == ST_FAIL);
            r_busy    <= (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_ADAPT) ||
                         (w_state_nxt == ST_LATCH);
            case (w_state_nxt)
                ST_ADAPT, ST_LATCH: r_op_mode <= MODE_INT_W;
                ST_HOLD:            r_op_mode <= MODE_EXT_W;
                default:            r_op_mode <= MODE_BYPASS;
            endcase
        end
    end

    // Warm-up, sample-budget and stability counters plus the previous-W copy.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_warm_cnt <= '0;
            r_stab_cnt <= '0;
            r_samp_cnt <= '0;
            r_prev_wr  <= '0;
            r_prev_wj  <= '0;
            r_prev_vld <= 1'b0;
        end else if (w_go) begin
            r_warm_cnt <= '0;
            r_stab_cnt <= '0;
            r_samp_cnt <= '0;
            r_prev_vld <= 1'b0;
        end else if ((r_state == ST_WARMUP) && sample_vld && !abort) begin
            r_warm_cnt <= w_warm_inc;
        end else if (w_adapt_smp) begin
            r_samp_cnt <= w_samp_inc;
            r_stab_cnt <= w_stab_nxt;
            r_prev_wr  <= Wr_mon;
            r_prev_wj  <= Wj_mon;
            r_prev_vld <= 1'b1;
        end
    end

    // Latched coefficients: captured on entry to LATCH, cleared while in FAIL.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_wr_ext <= '0;
            r_wj_ext <= '0;
        end else if (w_capture) begin
            r_wr_ext <= w_cap_wr;
            r_wj_ext <= w_cap_wj;
        end else if (w_state_nxt == ST_FAIL) begin
            r_wr_ext <= '0;
            r_wj_ext <= '0;
        end
    end

    assign op_mode       = r_op_mode;
    assign freeze_iqcomp = r_freeze;
    assign Wr_ext        = r_wr_ext;
    assign Wj_ext        = r_wj_ext;
    assign settled       = r_settled;
    assign timeout       = r_timeout;
    assign busy          = r_busy;
    assign state_dbg     = r_state;

endmodule
